logic_sweep_ctrl: RTL and testbench

Sequencing stage wrapped around the team's combinational N-bit logic generator (AND/OR/XOR/XNOR selected by a 2-bit function code). It accepts an operand pair over a valid/ready handshake and drives the pair into the generator. It then steps the function code through a selected subset of the four functions, one per cycle, capturing each result. The packed result vector is presented downstream over a second valid/ready handshake.

---
 rtl/logic_sweep_pkg.sv | 29 ++
 rtl/logic_sweep_ctrl_prio4.sv | 24 ++
 rtl/logic_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// ---------------------------------------------------------------------------
// logic_sweep_pkg
// Shared definitions for the logic sweep controller:
//   - state_e      : controller FSM states (IDLE / SWEEP / HOLD)
//   - FUNC_*       : function codes understood by the logic generator
//   - MASK_ALL     : mask used when a command requests no function at all
//   - effective_mask() : maps an empty request mask onto MASK_ALL
// ---------------------------------------------------------------------------
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] FUNC_AND  = 2'd0;
  localparam logic [1:0] FUNC_OR   = 2'd1;
  localparam logic [1:0] FUNC_XOR  = 2'd2;
  localparam logic [1:0] FUNC_XNOR = 2'd3;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // An all-zero request means "sweep every function".
  function automatic logic [3:0] effective_mask(input logic [3:0] req);
    effective_mask = (req == 4'b0000) ? MASK_ALL : req;
  endfunction

endpackage

// File: rtl/logic_sweep_ctrl_prio4.sv
// ---------------------------------------------------------------------------
// logic_sweep_prio4
// Lowest-set-bit priority encoder used to pick the next function code.
// Ports:
//   in_i  [3:0] : request vector
//   idx_o [1:0] : index of the lowest set bit (0 when in_i is all zero)
// ---------------------------------------------------------------------------
module logic_sweep_prio4 (
  input  logic [3:0] in_i,
  output logic [1:0] idx_o
);

  always_comb begin
    idx_o = 2'd0;
    casez (in_i)
      4'b???1: idx_o = 2'd0;
      4'b??10: idx_o = 2'd1;
      4'b?100: idx_o = 2'd2;
      4'b1000: idx_o = 2'd3;
      default: idx_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// logic_sweep_ctrl
// Sequencer wrapped around an external combinational N-bit logic generator.
// Accepts an operand pair plus a function mask, drives the operands into the
// generator, steps the function code through the requested functions (lowest
// code first, one per cycle), captures each result into its slot and then
// presents the packed bundle downstream.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : command handshake
//   in_a, in_b [N-1:0]  : operands
//   in_mask [3:0]       : requested functions (0 = all four)
//   op_a, op_b, op_func : drive the logic generator
//   op_result [N-1:0]   : generator result, same cycle
//   out_valid/out_ready : result handshake
//   out_data [4N-1:0]   : slot k = result of function k (0 if not selected)
//   out_done [3:0]      : effective mask of the bundle
//   out_zero [3:0]      : per-slot zero flags (only with LOGIC_SWEEP_ZFLAG_EN)
//
// Build option: define LOGIC_SWEEP_ZFLAG_EN to add the out_zero port.
// ---------------------------------------------------------------------------
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [3:0]     in_mask,
  output logic [N-1:0]   op_a,
  output logic [N-1:0]   op_b,
  output logic [1:0]     op_func,
  input  logic [N-1:0]   op_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_data,
  output logic [3:0]     out_done
`ifdef LOGIC_SWEEP_ZFLAG_EN
  ,
  output logic [3:0]     out_zero
`endif
);

  state_e         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   op_a_q;
  logic [N-1:0]   op_b_q;
  logic [1:0]     op_func_q;
  logic [4*N-1:0] data_q;
  logic [3:0]     done_q;
  logic [3:0]     rem_q;
`ifdef LOGIC_SWEEP_ZFLAG_EN
  logic [3:0]     zero_q;
`endif

  logic [3:0] eff_mask;
  logic [3:0] rem_d;
  logic [3:0] prio_in;
  logic [1:0] prio_idx;

  // One encoder serves both cases: at accept it picks the first function of
  // the new mask, during the sweep it picks the next function after the one
  // being captured, so op_func can be a plain register.
  always_comb begin
    eff_mask = effective_mask(in_mask);
    rem_d    = rem_q & ~(4'b0001 << op_func_q);
    prio_in  = (state_q == IDLE) ? eff_mask : rem_d;
  end

  logic_sweep_prio4 u_prio (
    .in_i  (prio_in),
    .idx_o (prio_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_func_q   <= FUNC_AND;
      data_q      <= '0;
      done_q      <= 4'b0000;
      rem_q       <= 4'b0000;
`ifdef LOGIC_SWEEP_ZFLAG_EN
      zero_q      <= 4'b0000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_q     <= in_a;
            op_b_q     <= in_b;
            rem_q      <= eff_mask;
            done_q     <= eff_mask;
            data_q     <= '0;
`ifdef LOGIC_SWEEP_ZFLAG_EN
            zero_q     <= 4'b0000;
`endif
            op_func_q  <= prio_idx;
            in_ready_q <= 1'b0;
            state_q    <= SWEEP;
          end
        end

        SWEEP: begin
          for (int k = 0; k < 4; k++) begin
            if (op_func_q == 2'(k)) begin
              data_q[k*N +: N] <= op_result;
`ifdef LOGIC_SWEEP_ZFLAG_EN
              zero_q[k]        <= (op_result == '0);
`endif
            end
          end
          rem_q <= rem_d;
          if (rem_d == 4'b0000) begin
            op_func_q   <= FUNC_AND;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            op_func_q   <= prio_idx;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          op_func_q   <= FUNC_AND;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_func   = op_func_q;
  assign out_data  = data_q;
  assign out_done  = done_q;
`ifdef LOGIC_SWEEP_ZFLAG_EN
  assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
module tb_logic_sweep_ctrl;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [3:0]     in_mask;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [1:0]     op_func;
  logic [N-1:0]   op_result;
  logic           out_valid;
  logic           out_ready;
  logic [4*N-1:0] out_data;
  logic [3:0]     out_done;
`ifdef LOGIC_SWEEP_ZFLAG_EN
  logic [3:0]     out_zero;
`endif

  logic_sweep_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mask   (in_mask),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_func   (op_func),
    .op_result (op_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_done  (out_done)
`ifdef LOGIC_SWEEP_ZFLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // The logic generator that lives at the parent level.
  always_comb begin
    case (op_func)
      2'd0:    op_result = op_a & op_b;
      2'd1:    op_result = op_a | op_b;
      2'd2:    op_result = op_a ^ op_b;
      default: op_result = ~(op_a ^ op_b);
    endcase
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4*N-1:0] data;
    logic [3:0]     done;
    logic [3:0]     zero;
    int             vcyc;
  } exp_t;

  exp_t sbq[$];

  int passed = 0;
  int total  = 0;
  int hs_edge  = 0;
  int last_acc = 0;
  logic [4*N-1:0] last_data = '0;
  int rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: slot k holds function k of (a,b) when requested.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [3:0] m);
    exp_t x;
    logic [3:0] e;
    logic [N-1:0] r;
    e = (m == 4'd0) ? 4'hF : m;
    x.data = '0;
    x.zero = 4'd0;
    x.done = e;
    x.vcyc = 0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       r = a & b;
        1:       r = a | b;
        2:       r = a ^ b;
        default: r = ~(a ^ b);
      endcase
      if (e[k]) begin
        x.data[k*N +: N] = r;
        x.zero[k] = (r == '0);
      end
    end
    return x;
  endfunction

  // out_ready driver, updated just after the rising edge so the monitor's
  // negedge sample is never racing it.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_v;
    exp_t x;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (sbq.size() == 0) begin
            check(1'b0, "unexpected_valid", 64'(out_data), 64'd0);
          end else begin
            x = sbq[0];
            if (!prev_v) check(cyc == x.vcyc, "valid_latency", 64'(cyc), 64'(x.vcyc));
            check(out_data == x.data, "out_data", 64'(out_data), 64'(x.data));
            check(out_done == x.done, "out_done", 64'(out_done), 64'(x.done));
`ifdef LOGIC_SWEEP_ZFLAG_EN
            check(out_zero == x.zero, "out_zero", 64'(out_zero), 64'(x.zero));
`endif
            check(in_ready == 1'b0 && op_func == 2'd0, "hold_ctrl",
                  64'({in_ready, op_func}), 64'd0);
            if (out_ready) begin
              hs_edge   = cyc + 1;
              last_data = out_data;
              void'(sbq.pop_front());
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic garbage();
    in_valid = 1'($urandom_range(0, 1));
    in_a     = N'($urandom);
    in_b     = N'($urandom);
    in_mask  = 4'($urandom);
  endtask

  // Issue one command; called at a negedge, returns at the negedge of the
  // first HOLD cycle. gap>0 checks the distance to the previous accept.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [3:0] m, input bit chk_hs, input int gap);
    exp_t x;
    int   budget;
    int   acc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mask  = m;
    budget   = 0;
    while (in_ready !== 1'b1) begin
      if (budget >= 300) begin
        check(1'b0, "accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      budget++;
    end
    acc    = cyc + 1;
    x      = model(a, b, m);
    x.vcyc = acc + $countones(x.done);
    sbq.push_back(x);
    if (chk_hs) check(acc == hs_edge + 1, "accept_after_hs", 64'(acc), 64'(hs_edge + 1));
    if (gap > 0) check(acc - last_acc == gap, "accept_gap", 64'(acc - last_acc), 64'(gap));
    last_acc = acc;
    @(negedge clk);
    garbage();
    for (int k = 0; k < 4; k++) begin
      if (x.done[k]) begin
        check({op_a, op_b, op_func, in_ready, out_valid} == {a, b, k[1:0], 2'b00},
              "sweep_step", 64'({op_a, op_b, op_func, in_ready, out_valid}),
              64'({a, b, k[1:0], 2'b00}));
        @(negedge clk);
        garbage();
      end
    end
    in_valid = 1'b0;
    check(op_func == 2'd0 && out_valid == 1'b1, "hold_entry",
          64'({op_func, out_valid}), 64'b001);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sbq.size() != 0) begin
      if (budget >= 300) begin
        check(1'b0, "drain_timeout", 64'(sbq.size()), 64'd0);
        sbq.delete();
        break;
      end
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_mask  = '0;
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    check({op_a, op_b, op_func, out_data, out_done, in_ready, out_valid} ==
          {8'd0, 8'd0, 2'd0, 32'd0, 4'd0, 1'b1, 1'b0}, "reset_state",
          64'({op_a, op_b, op_func, out_data, out_done, in_ready, out_valid}), 64'b10);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check(in_ready == 1'b1 && out_valid == 1'b0 && op_func == 2'd0, "idle_stays",
          64'({in_ready, out_valid, op_func}), 64'b1000);

    // Full sweep
    send(8'hF0, 8'h3C, 4'b0000, 1'b0, 0);
    drain();
    check(last_data == 32'h33CC_FC30, "full_sweep_data", 64'(last_data), 64'h33CCFC30);

    // Sparse mask: only XOR, which is zero
    send(8'hAA, 8'hAA, 4'b0100, 1'b0, 0);
    drain();
    check(last_data == 32'h0, "sparse_data", 64'(last_data), 64'd0);

    // Back-pressure, second command waiting with in_valid held high
    rdy_mode = 1;
    send(8'h12, 8'h34, 4'b0101, 1'b0, 0);
    fork
      begin
        repeat (10) @(negedge clk);
        rdy_mode = 0;
      end
      send(8'h56, 8'h78, 4'b1010, 1'b1, 0);
    join
    drain();

    // Reset in the second SWEEP cycle of a full sweep
    in_valid = 1'b1;
    in_a     = 8'hF0;
    in_b     = 8'h3C;
    in_mask  = 4'b0000;
    begin
      int budget;
      budget = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check(op_func == 2'd1, "abort_pre", 64'(op_func), 64'd1);
    rst = 1'b1;
    #1;
    check({op_a, op_b, op_func, out_data, out_done, in_ready, out_valid} ==
          {8'd0, 8'd0, 2'd0, 32'd0, 4'd0, 1'b1, 1'b0}, "abort_reset",
          64'({op_a, op_b, op_func, out_data, out_done, in_ready, out_valid}), 64'b10);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(!seen, "no_valid_after_abort", 64'(seen), 64'd0);

    // Back-to-back, two functions each
    send(8'h0F, 8'h55, 4'b0011, 1'b0, 0);
    send(8'hC3, 8'h99, 4'b0011, 1'b0, 4);
    drain();

    // Randomized commands with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 25; i++) begin
      send(N'($urandom), N'($urandom), 4'($urandom), 1'b0, 0);
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
